// File: rtl/char_reg_seq.sv
// Dot-product sequencer for digit recognition. Streams pixel/weight pairs for each class through
// the shared float multiply and add cores, then reports a score per class and the float argmax.
//
// state       | meaning
// ------------+-----------------------------------------------------------------
// IDLE        | waiting for start; result_* hold the last inference
// FETCH       | RAM/converter latency, addresses stable
// MUL_ISSUE   | present pix_f * weight_data to the multiplier (mult_nd high)
// MUL_WAIT    | wait for mult_rdy, capture product
// ADD_ISSUE   | present acc + product to the adder (add_nd high)
// ADD_WAIT    | wait for add_rdy, update acc, advance pixel or close class
// CLASS_END   | publish class score, update argmax, move to next class
// FIN         | one-cycle done pulse (normal end or timeout)

module char_reg_seq #(
    parameter int N_PIX   = 784,
    parameter int N_CLASS = 10,
    parameter int PIX_AW  = 10,
    parameter int W_AW    = 13,
    parameter int CLS_W   = 4,
    parameter int RAM_LAT = 1,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [PIX_AW-1:0] pic_addr,
    input  logic [31:0]       pix_f,
    output logic [W_AW-1:0]   weight_addr,
    input  logic [31:0]       weight_data,
    output logic [31:0]       mult_a,
    output logic [31:0]       mult_b,
    output logic              mult_nd,
    input  logic [31:0]       mult_result,
    input  logic              mult_rdy,
    output logic [31:0]       add_a,
    output logic [31:0]       add_b,
    output logic              add_nd,
    input  logic [31:0]       add_result,
    input  logic              add_rdy,
    output logic              score_valid,
    output logic [CLS_W-1:0]  score_class,
    output logic [31:0]       score,
    output logic [CLS_W-1:0]  result_class,
    output logic [31:0]       result_score
);

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_FETCH     = 3'd1;
    localparam logic [2:0] S_MUL_ISSUE = 3'd2;
    localparam logic [2:0] S_MUL_WAIT  = 3'd3;
    localparam logic [2:0] S_ADD_ISSUE = 3'd4;
    localparam logic [2:0] S_ADD_WAIT  = 3'd5;
    localparam logic [2:0] S_CLASS_END = 3'd6;
    localparam logic [2:0] S_FIN       = 3'd7;

    // Down-counters are loaded with (length - 1) and terminate at zero.
    localparam int LW = (RAM_LAT > 1) ? $clog2(RAM_LAT) : 1;
    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [LW-1:0] LAT_LOAD  = LW'(RAM_LAT - 1);
    localparam logic [TW-1:0] WAIT_LOAD = TW'(TIMEOUT - 1);

    logic [2:0]        state_q;
    logic [PIX_AW-1:0] pic_addr_q;
    logic [W_AW-1:0]   weight_addr_q;
    logic [CLS_W-1:0]  cls_q;
    logic [31:0]       acc_q;
    logic [31:0]       prod_q;
    logic [31:0]       mult_a_q;
    logic [31:0]       mult_b_q;
    logic [LW-1:0]     fetch_cnt_q;
    logic [TW-1:0]     wait_cnt_q;
    logic              err_q;
    logic [31:0]       best_score_q;
    logic [CLS_W-1:0]  best_cls_q;

    logic last_pix;
    logic last_cls;
    logic wait_expired;
    logic new_best;

    // Float ordering without NaN support; +0 and -0 compare equal.
    function automatic logic f_gt(input logic [31:0] a, input logic [31:0] b);
        logic gt;
        if (a[31] != b[31])
            gt = !a[31] && ((a[30:0] != 31'd0) || (b[30:0] != 31'd0));
        else if (!a[31])
            gt = a[30:0] > b[30:0];
        else
            gt = a[30:0] < b[30:0];
        return gt;
    endfunction

    assign last_pix     = (pic_addr_q == PIX_AW'(N_PIX - 1));
    assign last_cls     = (cls_q == CLS_W'(N_CLASS - 1));
    assign wait_expired = (wait_cnt_q == '0);
    assign new_best     = (cls_q == '0) || f_gt(acc_q, best_score_q);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_IDLE;
            pic_addr_q    <= '0;
            weight_addr_q <= '0;
            cls_q         <= '0;
            acc_q         <= 32'h0;
            prod_q        <= 32'h0;
            mult_a_q      <= 32'h0;
            mult_b_q      <= 32'h0;
            fetch_cnt_q   <= '0;
            wait_cnt_q    <= '0;
            err_q         <= 1'b0;
            best_score_q  <= 32'h0;
            best_cls_q    <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        pic_addr_q    <= '0;
                        weight_addr_q <= '0;
                        cls_q         <= '0;
                        acc_q         <= 32'h0;
                        err_q         <= 1'b0;
                        best_score_q  <= 32'h0;
                        best_cls_q    <= '0;
                        fetch_cnt_q   <= LAT_LOAD;
                        state_q       <= S_FETCH;
                    end
                end
                S_FETCH: begin
                    if (fetch_cnt_q == '0)
                        state_q <= S_MUL_ISSUE;
                    else
                        fetch_cnt_q <= fetch_cnt_q - 1'b1;
                end
                S_MUL_ISSUE: begin
                    mult_a_q   <= pix_f;
                    mult_b_q   <= weight_data;
                    wait_cnt_q <= WAIT_LOAD;
                    state_q    <= S_MUL_WAIT;
                end
                S_MUL_WAIT: begin
                    if (mult_rdy) begin
                        prod_q  <= mult_result;
                        state_q <= S_ADD_ISSUE;
                    end else if (wait_expired) begin
                        err_q   <= 1'b1;
                        state_q <= S_FIN;
                    end else begin
                        wait_cnt_q <= wait_cnt_q - 1'b1;
                    end
                end
                S_ADD_ISSUE: begin
                    wait_cnt_q <= WAIT_LOAD;
                    state_q    <= S_ADD_WAIT;
                end
                S_ADD_WAIT: begin
                    if (add_rdy) begin
                        acc_q <= add_result;
                        if (last_pix) begin
                            state_q <= S_CLASS_END;
                        end else begin
                            pic_addr_q    <= pic_addr_q + 1'b1;
                            weight_addr_q <= weight_addr_q + 1'b1;
                            fetch_cnt_q   <= LAT_LOAD;
                            state_q       <= S_FETCH;
                        end
                    end else if (wait_expired) begin
                        err_q   <= 1'b1;
                        state_q <= S_FIN;
                    end else begin
                        wait_cnt_q <= wait_cnt_q - 1'b1;
                    end
                end
                S_CLASS_END: begin
                    if (new_best) begin
                        best_score_q <= acc_q;
                        best_cls_q   <= cls_q;
                    end
                    acc_q         <= 32'h0;
                    pic_addr_q    <= '0;
                    // Weights are laid out class-major, so the address simply keeps counting.
                    weight_addr_q <= weight_addr_q + 1'b1;
                    if (last_cls) begin
                        state_q <= S_FIN;
                    end else begin
                        cls_q       <= cls_q + 1'b1;
                        fetch_cnt_q <= LAT_LOAD;
                        state_q     <= S_FETCH;
                    end
                end
                S_FIN: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    // Strobes are gated by rst so an abort removes them within the same cycle.
    assign busy        = (state_q != S_IDLE) && (state_q != S_FIN);
    assign done        = (state_q == S_FIN) && !rst;
    assign err         = err_q;
    assign pic_addr    = pic_addr_q;
    assign weight_addr = weight_addr_q;

    assign mult_nd = (state_q == S_MUL_ISSUE) && !rst;
    assign mult_a  = (state_q == S_MUL_ISSUE) ? pix_f : mult_a_q;
    assign mult_b  = (state_q == S_MUL_ISSUE) ? weight_data : mult_b_q;

    assign add_nd = (state_q == S_ADD_ISSUE) && !rst;
    assign add_a  = acc_q;
    assign add_b  = prod_q;

    assign score_valid  = (state_q == S_CLASS_END) && !rst;
    assign score_class  = cls_q;
    assign score        = acc_q;
    assign result_class = best_cls_q;
    assign result_score = best_score_q;

endmodule

// File: tb/tb_char_reg_seq.sv
// Bench for char_reg_seq: RAM and float-core models around the sequencer, with scores and argmax
// predicted from real-valued dot products of the loaded picture and weights.

module tb_char_reg_seq;

    localparam int N_PIX   = 4;
    localparam int N_CLASS = 3;
    localparam int PIX_AW  = 10;
    localparam int W_AW    = 13;
    localparam int CLS_W   = 4;
    localparam int RAM_LAT = 1;
    localparam int TIMEOUT = 255;
    localparam int N_W     = N_PIX * N_CLASS;

    logic              clk;
    logic              rst;
    logic              start;
    logic              busy, done, err;
    logic [PIX_AW-1:0] pic_addr;
    logic [31:0]       pix_f;
    logic [W_AW-1:0]   weight_addr;
    logic [31:0]       weight_data;
    logic [31:0]       mult_a, mult_b, mult_result;
    logic              mult_nd, mult_rdy;
    logic [31:0]       add_a, add_b, add_result;
    logic              add_nd, add_rdy;
    logic              score_valid;
    logic [CLS_W-1:0]  score_class, result_class;
    logic [31:0]       score, result_score;

    char_reg_seq #(
        .N_PIX(N_PIX), .N_CLASS(N_CLASS), .PIX_AW(PIX_AW), .W_AW(W_AW),
        .CLS_W(CLS_W), .RAM_LAT(RAM_LAT), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done), .err(err),
        .pic_addr(pic_addr), .pix_f(pix_f), .weight_addr(weight_addr), .weight_data(weight_data),
        .mult_a(mult_a), .mult_b(mult_b), .mult_nd(mult_nd), .mult_result(mult_result),
        .mult_rdy(mult_rdy), .add_a(add_a), .add_b(add_b), .add_nd(add_nd),
        .add_result(add_result), .add_rdy(add_rdy), .score_valid(score_valid),
        .score_class(score_class), .score(score), .result_class(result_class),
        .result_score(result_score)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] pic_mem [N_PIX];
    logic [31:0] w_mem   [N_W];
    logic [31:0] pix_set [5] = '{32'h00000000, 32'h3F000000, 32'h3F800000, 32'h40000000, 32'h40400000};
    logic [31:0] w_set   [7] = '{32'hC0000000, 32'hBF800000, 32'hBF000000, 32'h3E800000,
                                 32'h3F000000, 32'h3F800000, 32'h40000000};

    int  lm = 3;
    int  la = 3;
    bit  mult_block = 1'b0;
    bit  spur_en = 1'b0;

    function automatic real f2r(input logic [31:0] f);
        real r;
        int  e;
        if (f[30:0] == 31'd0) return 0.0;
        r = 1.0 + real'(f[22:0]) / 8388608.0;
        e = int'(f[30:23]) - 127;
        while (e > 0) begin r = r * 2.0; e--; end
        while (e < 0) begin r = r / 2.0; e++; end
        return f[31] ? -r : r;
    endfunction

    function automatic logic [31:0] r2f(input real r);
        real    a;
        int     e;
        longint m;
        logic   s;
        if (r == 0.0) return 32'h0;
        s = (r < 0.0);
        a = s ? -r : r;
        e = 127;
        while (a >= 2.0) begin a = a / 2.0; e++; end
        while (a < 1.0)  begin a = a * 2.0; e--; end
        m = $rtoi((a - 1.0) * 8388608.0 + 0.5);
        return {s, e[7:0], m[22:0]};
    endfunction

    function automatic logic [31:0] rd_pic(input int a);
        if (a < N_PIX) return pic_mem[a];
        return 32'h0;
    endfunction

    function automatic logic [31:0] rd_w(input int a);
        if (a < N_W) return w_mem[a];
        return 32'h0;
    endfunction

    // Synchronous-read RAMs with one cycle of latency.
    always @(posedge clk) begin
        pix_f       <= rd_pic(int'(pic_addr));
        weight_data <= rd_w(int'(weight_addr));
    end

    // Multiplier: rdy lm cycles after the nd cycle; can be muted to force a timeout.
    logic        m_busy = 1'b0;
    int          m_cnt = 0;
    logic [31:0] m_res = 32'h0;
    initial begin mult_rdy = 1'b0; mult_result = 32'h0; end
    always @(posedge clk) begin
        mult_rdy <= 1'b0;
        if (mult_nd) begin
            m_busy <= 1'b1;
            m_cnt  <= lm - 1;
            m_res  <= r2f(f2r(mult_a) * f2r(mult_b));
        end else if (m_busy) begin
            if (m_cnt <= 1) begin
                m_busy <= 1'b0;
                if (!mult_block) begin
                    mult_rdy    <= 1'b1;
                    mult_result <= m_res;
                end
            end else begin
                m_cnt <= m_cnt - 1;
            end
        end
    end

    // Adder: rdy la cycles after nd; optionally raises junk rdy while a multiply is pending.
    logic        a_busy = 1'b0;
    int          a_cnt = 0;
    logic [31:0] a_res = 32'h0;
    initial begin add_rdy = 1'b0; add_result = 32'h0; end
    always @(posedge clk) begin
        add_rdy <= 1'b0;
        if (add_nd) begin
            a_busy <= 1'b1;
            a_cnt  <= la - 1;
            a_res  <= r2f(f2r(add_a) + f2r(add_b));
        end else if (a_busy) begin
            if (a_cnt <= 1) begin
                a_busy     <= 1'b0;
                add_rdy    <= 1'b1;
                add_result <= a_res;
            end else begin
                a_cnt <= a_cnt - 1;
            end
        end else if (spur_en && m_busy) begin
            add_rdy    <= 1'b1;
            add_result <= 32'hDEADBEEF;
        end
    end

    logic [31:0] sc_q[$];
    int          sc_cls_q[$];
    int          iss_pic[$];
    int          iss_w[$];
    logic [31:0] iss_a[$];
    logic [31:0] iss_b[$];
    int          done_cnt = 0;

    always @(negedge clk) begin
        if (mult_nd === 1'b1) begin
            iss_pic.push_back(int'(pic_addr));
            iss_w.push_back(int'(weight_addr));
            iss_a.push_back(mult_a);
            iss_b.push_back(mult_b);
        end
        if (score_valid === 1'b1) begin
            sc_q.push_back(score);
            sc_cls_q.push_back(int'(score_class));
        end
        if (done === 1'b1) done_cnt <= done_cnt + 1;
    end

    logic [31:0] exp_score [N_CLASS];
    int          exp_best;

    task automatic model();
        real s;
        real best_r;
        best_r = 0.0;
        exp_best = 0;
        for (int c = 0; c < N_CLASS; c++) begin
            s = 0.0;
            for (int p = 0; p < N_PIX; p++)
                s = s + f2r(pic_mem[p]) * f2r(w_mem[c * N_PIX + p]);
            exp_score[c] = r2f(s);
            if (c == 0 || s > best_r) begin
                best_r   = s;
                exp_best = c;
            end
        end
    endtask

    task automatic load_uniform(input logic [31:0] w0, input logic [31:0] w1, input logic [31:0] w2);
        logic [31:0] wc;
        for (int p = 0; p < N_PIX; p++) pic_mem[p] = 32'h3F800000;
        for (int c = 0; c < N_CLASS; c++) begin
            wc = (c == 0) ? w0 : (c == 1) ? w1 : w2;
            for (int p = 0; p < N_PIX; p++) w_mem[c * N_PIX + p] = wc;
        end
    endtask

    task automatic clear_logs();
        sc_q.delete(); sc_cls_q.delete();
        iss_pic.delete(); iss_w.delete(); iss_a.delete(); iss_b.delete();
    endtask

    task automatic run_inf(input int extra_at, output int cyc, output bit ok);
        clear_logs();
        @(negedge clk);
        start = 1'b1;
        cyc = 0;
        ok = 1'b0;
        while (!ok && cyc < 5000) begin
            @(negedge clk);
            cyc++;
            start = (cyc == extra_at);
            if (done === 1'b1) ok = 1'b1;
        end
        start = 1'b0;
    endtask

    task automatic verify_inference(input string name, input int cyc, input bit ok);
        int exp_cyc;
        exp_cyc = N_CLASS * (N_PIX * (RAM_LAT + 2 + lm + la) + 1) + 1;
        n_checks++;
        if (!ok) begin n_fail++; $display("FAIL %s done_seen: got 0 expected 1", name); end
        n_checks++;
        if (cyc != exp_cyc) begin
            n_fail++; $display("FAIL %s latency: got %0d expected %0d", name, cyc, exp_cyc);
        end
        n_checks++;
        if ({busy, err} !== 2'b00) begin
            n_fail++; $display("FAIL %s busy_err_at_done: got %b expected 00", name, {busy, err});
        end
        n_checks++;
        if (sc_q.size() != N_CLASS) begin
            n_fail++; $display("FAIL %s score_count: got %0d expected %0d", name, sc_q.size(), N_CLASS);
        end
        for (int c = 0; c < N_CLASS && c < sc_q.size(); c++) begin
            n_checks++;
            if (sc_q[c] !== exp_score[c] || sc_cls_q[c] != c) begin
                n_fail++;
                $display("FAIL %s score[%0d]: got %h class %0d expected %h class %0d",
                         name, c, sc_q[c], sc_cls_q[c], exp_score[c], c);
            end
        end
        n_checks++;
        if (result_class !== CLS_W'(exp_best) || result_score !== exp_score[exp_best]) begin
            n_fail++;
            $display("FAIL %s argmax: got class %0d score %h expected class %0d score %h",
                     name, result_class, result_score, exp_best, exp_score[exp_best]);
        end
        n_checks++;
        if (iss_pic.size() != N_W) begin
            n_fail++; $display("FAIL %s issue_count: got %0d expected %0d", name, iss_pic.size(), N_W);
        end
        for (int k = 0; k < N_W && k < iss_pic.size(); k++) begin
            n_checks++;
            if (iss_pic[k] != k % N_PIX || iss_w[k] != k ||
                iss_a[k] !== pic_mem[k % N_PIX] || iss_b[k] !== w_mem[k]) begin
                n_fail++;
                $display("FAIL %s issue[%0d]: got pic %0d w %0d a %h b %h expected pic %0d w %0d a %h b %h",
                         name, k, iss_pic[k], iss_w[k], iss_a[k], iss_b[k],
                         k % N_PIX, k, pic_mem[k % N_PIX], w_mem[k]);
            end
        end
        @(negedge clk);
        n_checks++;
        if (done !== 1'b0) begin
            n_fail++; $display("FAIL %s done_width: got %b expected 0", name, done);
        end
    endtask

    task automatic test_reset();
        logic [263:0] obs;
        rst = 1'b1;
        start = 1'b0;
        repeat (3) @(negedge clk);
        obs = {busy, done, err, mult_nd, add_nd, score_valid, pic_addr, weight_addr, mult_a, mult_b,
               add_a, add_b, score_class, score, result_class, result_score};
        n_checks++;
        if (obs !== '0) begin n_fail++; $display("FAIL reset_outputs: got %h expected 0", obs); end
        rst = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({busy, done, err} !== 3'b000) begin
            n_fail++; $display("FAIL reset_idle: got %b expected 000", {busy, done, err});
        end
    endtask

    task automatic test_basic();
        int cyc; bit ok;
        lm = 3; la = 3;
        load_uniform(32'h3F000000, 32'h3F800000, 32'h3E800000);
        model();
        run_inf(-1, cyc, ok);
        verify_inference("basic", cyc, ok);
    endtask

    task automatic test_tie();
        int cyc; bit ok;
        lm = 3; la = 3;
        load_uniform(32'h3F800000, 32'h3F800000, 32'h3F800000);
        model();
        run_inf(-1, cyc, ok);
        verify_inference("tie", cyc, ok);
    endtask

    task automatic test_negative();
        int cyc; bit ok;
        lm = 3; la = 3;
        load_uniform(32'hBE800000, 32'hBF000000, 32'hBF000000);
        model();
        run_inf(-1, cyc, ok);
        verify_inference("negative", cyc, ok);
    endtask

    task automatic test_timeout();
        int cyc, nd_cyc; bit ok, seen;
        lm = 3; la = 3;
        load_uniform(32'h3F000000, 32'h3F800000, 32'h3E800000);
        mult_block = 1'b1;
        clear_logs();
        @(negedge clk);
        start = 1'b1;
        cyc = 0; nd_cyc = -1; seen = 1'b0;
        while (!seen && cyc < TIMEOUT + 50) begin
            @(negedge clk);
            start = 1'b0;
            cyc++;
            if (mult_nd === 1'b1 && nd_cyc < 0) nd_cyc = cyc;
            if (done === 1'b1) seen = 1'b1;
        end
        n_checks++;
        if (!seen) begin n_fail++; $display("FAIL timeout_done: got 0 expected 1"); end
        n_checks++;
        if (cyc - nd_cyc != TIMEOUT + 1) begin
            n_fail++; $display("FAIL timeout_latency: got %0d expected %0d", cyc - nd_cyc, TIMEOUT + 1);
        end
        n_checks++;
        if ({err, busy, mult_nd, add_nd} !== 4'b1000) begin
            n_fail++; $display("FAIL timeout_flags: got %b expected 1000", {err, busy, mult_nd, add_nd});
        end
        @(negedge clk);
        n_checks++;
        if ({done, err} !== 2'b01) begin
            n_fail++; $display("FAIL timeout_after: got %b expected 01", {done, err});
        end
        mult_block = 1'b0;
        repeat (10) @(negedge clk);
        n_checks++;
        if (err !== 1'b1) begin n_fail++; $display("FAIL timeout_err_hold: got %b expected 1", err); end
        model();
        run_inf(-1, cyc, ok);
        verify_inference("after_timeout", cyc, ok);
    endtask

    task automatic test_reset_mid();
        int cnt, d0, cyc; bit hit, ok;
        lm = 3; la = 3;
        load_uniform(32'h3F000000, 32'h3F800000, 32'h3E800000);
        clear_logs();
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        cnt = 0; hit = 1'b0;
        while (!hit && cnt < 500) begin
            @(negedge clk);
            cnt++;
            if (sc_q.size() >= 1 && mult_nd === 1'b1) hit = 1'b1;
        end
        n_checks++;
        if (!hit) begin n_fail++; $display("FAIL abort_reach_class1: got 0 expected 1"); end
        d0 = done_cnt;
        rst = 1'b1;
        #1;
        n_checks++;
        if (mult_nd !== 1'b0) begin n_fail++; $display("FAIL abort_nd_drop: got %b expected 0", mult_nd); end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (10) @(negedge clk);
        n_checks++;
        if (done_cnt != d0) begin n_fail++; $display("FAIL abort_no_done: got %0d expected %0d", done_cnt, d0); end
        n_checks++;
        if ({busy, pic_addr, weight_addr} !== '0) begin
            n_fail++; $display("FAIL abort_idle: got busy %b pic %0d w %0d expected 0", busy, pic_addr, weight_addr);
        end
        model();
        run_inf(-1, cyc, ok);
        verify_inference("after_abort", cyc, ok);
    endtask

    task automatic test_back_to_back();
        int cyc; bit ok;
        lm = 3; la = 3;
        load_uniform(32'h3F000000, 32'h3F800000, 32'h3E800000);
        model();
        spur_en = 1'b1;
        run_inf(20, cyc, ok);
        spur_en = 1'b0;
        verify_inference("busy_start_spurious", cyc, ok);
        repeat (5) @(negedge clk);
        n_checks++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL busy_start_ignored: got busy %b expected 0", busy); end
    endtask

    task automatic test_random();
        int cyc; bit ok;
        for (int it = 0; it < 3; it++) begin
            lm = int'($urandom_range(2, 5));
            la = int'($urandom_range(2, 5));
            for (int p = 0; p < N_PIX; p++) pic_mem[p] = pix_set[$urandom_range(0, 4)];
            for (int k = 0; k < N_W; k++) w_mem[k] = w_set[$urandom_range(0, 6)];
            model();
            run_inf(-1, cyc, ok);
            verify_inference($sformatf("random%0d", it), cyc, ok);
        end
    endtask

    initial begin
        start = 1'b0;
        rst = 1'b1;
        test_reset();
        test_basic();
        test_tie();
        test_negative();
        test_timeout();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/char_reg_seq.md
Name: char_reg_seq

Overview:
- Sequencer for the digit-recognition dot-product datapath.
- For each of N_CLASS classes, it walks N_PIX pixel/weight pairs from the picture and weight block RAMs.
- Each pixel (converted to float by the external uchar2float path) is multiplied by its weight on the shared float_mult core. The product is accumulated on the shared float_add core using nd/rdy handshakes.
- Emits one score per class and the winning class (float argmax).

Parameters:
- N_PIX, 784, pixels per image
- N_CLASS, 10, number of classes
- PIX_AW, 10, picture RAM address width
- W_AW, 13, weight RAM address width (must cover N_PIX*N_CLASS)
- CLS_W, 4, class index width
- RAM_LAT, 1, cycles from address to valid RAM/converter data
- TIMEOUT, 255, max cycles to wait for any core rdy

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- start  in  1  begin inference (pulse)
- busy  out  1  high from accepted start to done
- done  out  1  one-cycle pulse at end (normal or error)
- err  out  1  timeout flag; held until next accepted start
- pic_addr  out  PIX_AW  picture RAM address
- pix_f  in  32  float pixel (RAM -> uchar2float)
- weight_addr  out  W_AW  weight RAM address
- weight_data  in  32  float weight
- mult_a, mult_b  out  32  multiplier operands
- mult_nd  out  1  multiplier new-data strobe
- mult_result  in  32  product
- mult_rdy  in  1  product valid
- add_a, add_b  out  32  adder operands
- add_nd  out  1  adder new-data strobe
- add_result  in  32  sum
- add_rdy  in  1  sum valid
- score_valid  out  1  one-cycle pulse per finished class
- score_class  out  CLS_W  class of score
- score  out  32  accumulated float for score_class
- result_class  out  CLS_W  argmax class, valid at done
- result_score  out  32  argmax score

Behaviour:
- Reset:
  - state IDLE; all outputs 0; accumulator 32'h0; counters 0.
  - rst mid-operation aborts immediately. No done pulse; nd strobes drop the same cycle.
- States: IDLE, FETCH, MUL_ISSUE, MUL_WAIT, ADD_ISSUE, ADD_WAIT, CLASS_END, FIN.
- IDLE:
  - start=1 -> pic_addr=0, weight_addr=0, acc=0, class=0, err cleared, busy=1 -> FETCH.
  - start while busy is ignored.
- FETCH: lasts RAM_LAT cycles; addresses held stable.
- MUL_ISSUE:
  - 1 cycle; mult_a=pix_f, mult_b=weight_data, mult_nd=1.
  - Operands held stable until rdy.
- MUL_WAIT:
  - On mult_rdy, capture mult_result -> ADD_ISSUE.
- ADD_ISSUE: 1 cycle; add_a=acc, add_b=product, add_nd=1.
- ADD_WAIT:
  - On add_rdy, acc<=add_result.
  - If pixel==N_PIX-1 -> CLASS_END.
  - Else pic_addr+1, weight_addr+1 -> FETCH.
- Only one operation in flight per core. rdy seen outside its WAIT state is ignored.
- Per-element cycles = RAM_LAT + 2 + Lm + La, where Lm/La = core latency measured from the nd cycle to the rdy cycle.
- CLASS_END (1 cycle):
  - score_valid=1, score=acc, score_class=class.
  - Argmax update: class 0 always loads best. Later classes replace best only if strictly greater.
  - Float compare:
    - Signs differ -> positive wins; +0 and -0 are equal.
    - Both positive -> larger [30:0] wins.
    - Both negative -> smaller [30:0] wins.
    - NaN not handled.
  - Then acc=0, pic_addr=0, weight_addr+1 (continues linearly, i.e. class*N_PIX+pixel), class+1 -> FETCH.
  - If last class -> FIN.
- FIN:
  - done=1 for one cycle; busy=0; result_class/result_score hold until next start -> IDLE.
- Timeout:
  - A wait counter clears on entry to MUL_WAIT/ADD_WAIT.
  - If it reaches TIMEOUT without rdy: err=1, strobes low, done pulse, busy=0 -> IDLE.
  - result_* are invalid in this case.
- pix_f and weight_data are sampled only in MUL_ISSUE.

Test Plan:
- N_PIX=4, N_CLASS=3, pix_f=3F800000. Weights 0.5/1.0/0.25 per class; core models Lm=La=3. -> scores 40000000, 40800000, 3F800000 in class order; result_class=1; done 1 cycle; per element 9 cycles.
- Tie: all classes weight 1.0 -> three scores 40800000; result_class=0.
- Negatives: class0 weights -0.25, classes 1-2 -0.5 -> scores BF800000, C0000000, C0000000; result_class=0.
- Hold mult_rdy low -> err=1 and done exactly TIMEOUT cycles after MUL_WAIT entry; mult_nd low; busy=0; then a normal run clears err.
- Assert rst mid-class, then start -> no done from aborted run; addresses restart at 0; scores match the first scenario.
- start pulsed while busy, plus spurious add_rdy in MUL_WAIT -> ignored; results identical to the first scenario.
